ofm_ram_writer: RTL and testbench



---
 rtl/ofm_ram_writer.sv | 201 ++++++++++++++++++++
 tb/tb_ofm_ram_writer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_ram_writer.sv
// ofm_ram_writer
// ---------------------------------------------------------------------------
// Consumer end of a conv layer's output interface. Each sample pulse captures
// a DSP_NO-channel ofm vector into a shadow register. The vector is then
// written into the activation RAM, LANES channels per beat, over
// BEATS = DSP_NO/LANES consecutive cycles. ram_feedback stays high while a
// captured vector is still being written, so the layer cannot finish before
// its last pixel is committed.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   layer_start  one-cycle pulse; restarts the pixel count and clears flags
//   sample       one-cycle pulse; ofm is valid in this cycle
//   ofm          [0:DSP_NO-1] array of WIDTH-bit channel values
//   ram_we       RAM write enable (registered)
//   ram_addr     RAM word address = pixel*BEATS + beat (registered)
//   ram_wdata    LANES channels; the lowest channel of the beat is in the LSBs
//   ram_feedback high while the current vector is being written
//   layer_done   level; all WOUT*WOUT pixels have been written
//   overrun      sticky; a sample arrived while it could not be accepted
// ---------------------------------------------------------------------------
module ofm_ram_writer #(
  parameter int WOUT   = 32,
  parameter int DSP_NO = 128,
  parameter int WIDTH  = 16,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2(WOUT*WOUT*DSP_NO/LANES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     layer_start,
  input  logic                     sample,
  input  logic [WIDTH-1:0]         ofm [0:DSP_NO-1],
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [LANES*WIDTH-1:0]   ram_wdata,
  output logic                     ram_feedback,
  output logic                     layer_done,
  output logic                     overrun
);

  localparam int BEATS  = DSP_NO / LANES;
  localparam int NPIX   = WOUT * WOUT;
  // One extra bit so the final count NPIX is representable without wrapping.
  localparam int PIX_W  = $clog2(NPIX) + 1;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    DONE
  } state_t;

  state_t             state, state_nx;
  logic [PIX_W-1:0]   pixel_cnt, pixel_cnt_nx;
  logic [BEAT_W-1:0]  beat, beat_nx;
  logic [WIDTH-1:0]   shadow [0:DSP_NO-1];

  logic                   load_shadow;
  logic                   emit;
  logic                   emit_from_ofm;
  logic [BEAT_W-1:0]      emit_beat;
  logic [PIX_W-1:0]       emit_pix;
  logic [IDX_W-1:0]       base_idx;

  logic                   we_nx;
  logic                   fb_nx;
  logic [ADDR_W-1:0]      addr_nx;
  logic [LANES*WIDTH-1:0] wdata_nx;
  logic                   done_nx;
  logic                   ovr_nx;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [PIX_W-1:0]  pix,
                                                input logic [BEAT_W-1:0] b);
    logic [31:0] full;
    full = 32'(pix) * 32'(BEATS) + 32'(b);
    return full[ADDR_W-1:0];
  endfunction

  // Next-state logic. The registers always describe the beat currently on
  // the RAM port, so "beat == BEATS-1" means the last beat of the vector is
  // being written right now; a sample in that cycle can be taken without a
  // bubble because its first beat only appears on the following cycle.
  always_comb begin
    state_nx      = state;
    pixel_cnt_nx  = pixel_cnt;
    beat_nx       = beat;
    load_shadow   = 1'b0;
    emit          = 1'b0;
    emit_from_ofm = 1'b0;
    emit_beat     = '0;
    emit_pix      = pixel_cnt;
    done_nx       = layer_done;
    ovr_nx        = overrun;

    if (layer_start) begin
      // Abort whatever is in flight; a coincident sample is ignored.
      state_nx     = IDLE;
      pixel_cnt_nx = '0;
      beat_nx      = '0;
      done_nx      = 1'b0;
      ovr_nx       = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample) begin
            load_shadow   = 1'b1;
            beat_nx       = '0;
            state_nx      = DRAIN;
            emit          = 1'b1;
            emit_from_ofm = 1'b1;
          end
        end
        DRAIN: begin
          if (beat == BEAT_W'(BEATS - 1)) begin
            pixel_cnt_nx = pixel_cnt + PIX_W'(1);
            if (pixel_cnt_nx == PIX_W'(NPIX)) begin
              // Layer complete; there is no pixel left to hold a new vector.
              state_nx = DONE;
              done_nx  = 1'b1;
              if (sample) ovr_nx = 1'b1;
            end else if (sample) begin
              load_shadow   = 1'b1;
              beat_nx       = '0;
              emit          = 1'b1;
              emit_from_ofm = 1'b1;
              emit_pix      = pixel_cnt_nx;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            beat_nx   = beat + BEAT_W'(1);
            emit      = 1'b1;
            emit_beat = beat + BEAT_W'(1);
            if (sample) ovr_nx = 1'b1;
          end
        end
        DONE: begin
          done_nx = 1'b1;
          if (sample) ovr_nx = 1'b1;
        end
        default: begin
          state_nx = IDLE;
        end
      endcase
    end

    we_nx   = emit;
    fb_nx   = emit;
    addr_nx = emit ? addr_of(emit_pix, emit_beat) : ram_addr;
  end

  // Beat data. The first beat of a freshly sampled vector comes straight
  // from ofm, because the shadow register is only loaded on the same edge.
  always_comb begin
    wdata_nx = ram_wdata;
    base_idx = IDX_W'(32'(emit_beat) * 32'(LANES));
    if (emit) begin
      for (int l = 0; l < LANES; l++) begin
        if (emit_from_ofm)
          wdata_nx[l*WIDTH +: WIDTH] = ofm[IDX_W'(l)];
        else
          wdata_nx[l*WIDTH +: WIDTH] = shadow[base_idx + IDX_W'(l)];
      end
    end
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pixel_cnt    <= '0;
      beat         <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_feedback <= 1'b0;
      layer_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nx;
      pixel_cnt    <= pixel_cnt_nx;
      beat         <= beat_nx;
      ram_we       <= we_nx;
      ram_addr     <= addr_nx;
      ram_wdata    <= wdata_nx;
      ram_feedback <= fb_nx;
      layer_done   <= done_nx;
      overrun      <= ovr_nx;
    end
  end

  // Shadow vector; its contents are meaningless until the first capture,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_shadow) shadow <= ofm;
  end

endmodule

// File: tb/tb_ofm_ram_writer.sv
// tb_ofm_ram_writer
// Scoreboard bench for ofm_ram_writer at default parameters. Every accepted
// sample pushes its BEATS expected RAM writes; a monitor pops and compares
// them whenever the DUT asserts ram_we.
module tb_ofm_ram_writer;

  localparam int WOUT   = 32;
  localparam int DSP_NO = 128;
  localparam int WIDTH  = 16;
  localparam int LANES  = 4;
  localparam int BEATS  = DSP_NO / LANES;
  localparam int NPIX   = WOUT * WOUT;
  localparam int ADDR_W = 15;
  localparam int BW     = LANES * WIDTH;

  logic                clk = 1'b0;
  logic                rst;
  logic                layer_start;
  logic                sample;
  logic [WIDTH-1:0]    ofm [0:DSP_NO-1];
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [BW-1:0]       ram_wdata;
  logic                ram_feedback;
  logic                layer_done;
  logic                overrun;

  always #5 clk = ~clk;

  ofm_ram_writer #(
    .WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH), .LANES(LANES), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .layer_start(layer_start),
    .sample(sample),
    .ofm(ofm),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_feedback(ram_feedback),
    .layer_done(layer_done),
    .overrun(overrun)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BW-1:0]     data;
  } beat_t;

  beat_t sb[$];
  int    n_cmp  = 0;
  int    n_bad  = 0;
  int    tb_pix = 0;
  bit    mon_en = 1'b0;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [BW-1:0] got,
                             input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fill ofm with base+i, or with random data when rnd is set.
  task automatic fillVector(input bit rnd, input logic [WIDTH-1:0] base);
    for (int i = 0; i < DSP_NO; i++)
      ofm[i] = rnd ? WIDTH'($urandom) : base + WIDTH'(i);
  endtask

  // Pulse sample for one cycle; if the DUT should accept it, push the
  // expected beats for the next pixel. Returns one cycle later (cycle t+1).
  task automatic applyStimulus(input bit accept);
    beat_t e;
    sample = 1'b1;
    if (accept) begin
      for (int b = 0; b < BEATS; b++) begin
        e.addr = ADDR_W'(tb_pix * BEATS + b);
        for (int l = 0; l < LANES; l++)
          e.data[l*WIDTH +: WIDTH] = ofm[b*LANES + l];
        sb.push_back(e);
      end
      tb_pix++;
    end
    @(negedge clk);
    sample = 1'b0;
  endtask

  // Monitor: every write must match the oldest expected beat.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_we) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_write", BW'(ram_we), BW'(0));
        end else begin
          beat_t e;
          e = sb.pop_front();
          checkOutput("addr", BW'(ram_addr), BW'(e.addr));
          checkOutput("wdata", ram_wdata, e.data);
          checkOutput("feedback_in_beat", BW'(ram_feedback), BW'(1));
        end
      end else begin
        checkOutput("feedback_idle", BW'(ram_feedback), BW'(0));
      end
    end
  end

  initial begin
    #(10 * 200000);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [BW-1:0] first_beat;
    rst = 1'b1; layer_start = 1'b0; sample = 1'b0;
    fillVector(1'b0, '0);
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rst_we", BW'(ram_we), BW'(0));
    checkOutput("rst_addr", BW'(ram_addr), BW'(0));
    checkOutput("rst_wdata", ram_wdata, BW'(0));
    checkOutput("rst_fb", BW'(ram_feedback), BW'(0));
    checkOutput("rst_done", BW'(layer_done), BW'(0));
    checkOutput("rst_ovr", BW'(overrun), BW'(0));
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk); layer_start = 1'b1;
    @(negedge clk); layer_start = 1'b0;
    tb_pix = 0;
    @(negedge clk);

    // Single vector then back-to-back second vector
    $display("[TB] single and back-to-back vectors");
    fillVector(1'b0, 16'h0000);
    applyStimulus(1'b1);
    first_beat = {16'd3, 16'd2, 16'd1, 16'd0};
    checkOutput("first_wdata", ram_wdata, first_beat);
    checkOutput("first_addr", BW'(ram_addr), BW'(0));
    for (int k = 1; k <= BEATS; k++) begin
      checkOutput("we_vec1", BW'(ram_we), BW'(1));
      if (k < BEATS) @(negedge clk);
    end
    fillVector(1'b0, 16'hA000);
    applyStimulus(1'b1);
    checkOutput("second_addr", BW'(ram_addr), BW'(32));
    for (int k = 1; k <= BEATS; k++) begin
      checkOutput("we_vec2", BW'(ram_we), BW'(1));
      if (k < BEATS) @(negedge clk);
    end
    @(negedge clk);
    checkOutput("we_after", BW'(ram_we), BW'(0));
    checkOutput("fb_after", BW'(ram_feedback), BW'(0));
    checkOutput("ovr_b2b", BW'(overrun), BW'(0));

    // Overrun: second sample at t+10 is dropped
    $display("[TB] overrun");
    fillVector(1'b1, '0);
    applyStimulus(1'b1);
    repeat (9) @(negedge clk);
    checkOutput("ovr_before", BW'(overrun), BW'(0));
    fillVector(1'b1, '0);
    applyStimulus(1'b0);
    checkOutput("ovr_set", BW'(overrun), BW'(1));
    repeat (22) @(negedge clk);
    checkOutput("we_after_ovr", BW'(ram_we), BW'(0));

    // Pixels 3 and 4, then abort pixel 5 at beat 10
    $display("[TB] abort");
    for (int p = 0; p < 2; p++) begin
      fillVector(1'b1, '0);
      applyStimulus(1'b1);
      repeat (BEATS) @(negedge clk);
    end
    checkOutput("ovr_sticky", BW'(overrun), BW'(1));
    fillVector(1'b1, '0);
    applyStimulus(1'b1);
    repeat (10) @(negedge clk);
    checkOutput("abort_beat10_addr", BW'(ram_addr), BW'(5 * BEATS + 10));
    layer_start = 1'b1;
    sample = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
    sample = 1'b0;
    sb.delete();
    checkOutput("abort_we", BW'(ram_we), BW'(0));
    checkOutput("abort_ovr", BW'(overrun), BW'(0));
    checkOutput("abort_done", BW'(layer_done), BW'(0));
    tb_pix = 0;
    repeat (3) @(negedge clk);
    fillVector(1'b1, '0);
    applyStimulus(1'b1);
    checkOutput("restart_addr", BW'(ram_addr), BW'(0));
    repeat (BEATS) @(negedge clk);

    // Reset in the middle of a vector
    $display("[TB] reset mid-drain");
    fillVector(1'b1, '0);
    applyStimulus(1'b1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    checkOutput("rst_mid_we", BW'(ram_we), BW'(0));
    checkOutput("rst_mid_addr", BW'(ram_addr), BW'(0));
    checkOutput("rst_mid_wdata", ram_wdata, BW'(0));
    checkOutput("rst_mid_fb", BW'(ram_feedback), BW'(0));
    checkOutput("rst_mid_done", BW'(layer_done), BW'(0));
    checkOutput("rst_mid_ovr", BW'(overrun), BW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checkOutput("rst_quiet_we", BW'(ram_we), BW'(0));
      @(negedge clk);
    end

    // Full layer, vectors back to back
    $display("[TB] full layer");
    layer_start = 1'b1;
    @(negedge clk);
    layer_start = 1'b0;
    tb_pix = 0;
    @(negedge clk);
    for (int p = 0; p < NPIX; p++) begin
      fillVector(1'b1, '0);
      applyStimulus(1'b1);
      repeat (BEATS - 1) @(negedge clk);
    end
    checkOutput("last_addr", BW'(ram_addr), BW'(32767));
    checkOutput("last_we", BW'(ram_we), BW'(1));
    checkOutput("done_early", BW'(layer_done), BW'(0));
    @(negedge clk);
    checkOutput("done_set", BW'(layer_done), BW'(1));
    checkOutput("done_fb", BW'(ram_feedback), BW'(0));
    checkOutput("done_we", BW'(ram_we), BW'(0));
    checkOutput("done_ovr", BW'(overrun), BW'(0));
    fillVector(1'b1, '0);
    applyStimulus(1'b0);
    checkOutput("done_sample_ovr", BW'(overrun), BW'(1));
    checkOutput("done_hold", BW'(layer_done), BW'(1));
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", BW'(sb.size()), BW'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
